arbiter2_leaf_ctrl: RTL and testbench
=====================================

// Module: arbiter2_leaf_ctrl
// PURPOSE
// - Synchronous 2:1 packet arbiter for the NoC leaf. It is the merge-side counterpart of the 2-way leaf decoder.
// - Shares one output flit channel between two input flit channels with round-robin fairness.
// - Packets are never interleaved: once a head flit wins, the grant is locked until its tail flit passes.
// - For every granted packet it emits a 1-bit route token on S. The return-path decoder consumes S as its select.
// PARAMETERS
// - W         9      flit width in bits. The flit carries its tail flag at bit TAIL_BIT.
// - TAIL_BIT  W-1    flit bit that marks the last flit of a packet. 1 = tail.
// PORTS
// - CLK        in   1  single clock, rising edge
// - _RESET     in   1  asynchronous, active-low reset
// - in0_data   in   W  flit from requester 0
// - in0_valid  in   1  requester 0 offers a flit
// - in0_ready  out  1  flit accepted on in0 this cycle (valid&ready)
// - in1_data   in   W  flit from requester 1
// - in1_valid  in   1  requester 1 offers a flit
// - in1_ready  out  1  flit accepted on in1 this cycle
// - out_data   out  W  registered output flit
// - out_valid  out  1  out_data holds a flit
// - out_ready  in   1  downstream accepts the flit
// - s_data     out  1  route token: index of the winning input
// - s_valid    out  1  token pending
// - s_ready    in   1  token consumer accepts
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, s_valid=0, s_data=0, state=IDLE, prio=0, in*_ready=0.
//   Reset acts immediately on assertion.
// - Handshakes: valid/ready on all three channels. A transfer occurs when both are high at a CLK edge.
//   - valid, once raised, must not drop until the transfer; data is held stable meanwhile.
// - Output stage: single-entry register.
//   - can_take = !out_valid | out_ready.
//   - Latency is 1 cycle from input acceptance to out_valid.
//   - Full throughput is 1 flit/cycle under continuous out_ready.
// - head_ok = can_take & (!s_valid | s_ready). The S slot must be free or draining this cycle.
// - FSM states: IDLE, LOCK0, LOCK1.
//   - IDLE:
//     - winner = prio if in[prio]_valid, else the other input if its valid is high, else none.
//     - in[winner]_ready = head_ok. The other input's ready is 0.
//     - On a head transfer: s_valid<=1, s_data<=winner, prio<=~winner.
//     - If the head flit is a tail (1-flit packet), stay in IDLE; otherwise go to LOCK[winner].
//   - LOCKi:
//     - in_i_ready = can_take; the other input's ready is 0.
//     - S is not touched.
//     - On transfer of a flit with TAIL_BIT=1, go to IDLE.
// - Simultaneous requests in IDLE: prio decides. After each grant, prio points at the loser, so strict alternation holds under contention.
// - s_valid clears on s_ready unless a new head transfers in the same cycle. In that case the register reloads with the new winner (no bubble).
// - Backpressure:
//   - out_ready=0 with out_valid=1 holds out_data and forces all in*_ready=0.
//   - s_valid=1 with s_ready=0 blocks new heads only; a locked packet body continues.
// - in*_ready is combinational from state, valids, out_ready and s_ready.
//   - There is no combinational path from data to ready.
//   - No ready depends on its own valid, except through winner selection in IDLE.
// - Reset mid-packet: the partial packet is abandoned; FSM goes to IDLE and the pending output/S are dropped. Upstream restart is a system-level reset concern.
// - Illegal: a valid drop before transfer is not checked by RTL. The bench asserts on it.
// STRUCTURE
// - Package noc_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t
//   - localparam int FLIT_W = 9
//   - function is_tail(flit)
// - Sub-module flit_reg_stage #(W): single-entry valid/ready register with async active-low reset.
//   - Used for the output channel; a 1-bit instance is used for S.
// - Top holds the FSM, the prio flop and the winner mux.
// TESTING
// - T1: after reset, in0 sends 9'h155 (tail=1), s_ready=out_ready=1.
//   -> next cycle out_valid=1, out_data=9'h155; s_valid=1, s_data=0; prio=1.
// - T2: in0 and in1 both present 1-flit heads (9'h101, 9'h102) from reset.
//   -> out order 9'h101 then 9'h102, S tokens 0 then 1, back-to-back with no bubble.
// - T3: in0 sends 3 flits 9'h011, 9'h012, 9'h113; in1 raises 9'h1AA during flit 2.
//   -> in1_ready stays 0 until 9'h113 transfers; 9'h1AA is output next; S = 0, 1.
// - T4: out_ready=0 for 4 cycles with out_valid=1.
//   -> out_data stable, in0_ready=in1_ready=0; after release, 1 flit/cycle resumes with no loss or duplication.
// - T5: s_ready=0 with s_valid=1 while in0 is locked mid-packet.
//   -> body and tail flits still pass; the next head (either input) stalls until s_ready=1.
// - T6: _RESET pulsed low in LOCK1 between flits.
//   -> out_valid, s_valid and readies drop at once; after release, state=IDLE, prio=0, in0 head wins first.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC leaf 2:1 packet arbiter.
package noc_arb_pkg;

    localparam int FLIT_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // The tail flag lives in the MSB of a default-width flit.
    function automatic logic is_tail(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1];
    endfunction

endpackage

// File: rtl/flit_reg_stage.sv
// Single-entry valid/ready register; accepts a new entry while the held one drains.
module flit_reg_stage #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         load;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign load       = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/arbiter2_leaf_ctrl.sv
// 2:1 round-robin packet arbiter: merges two flit channels without interleaving
// packets and emits the winning input index as a route token on S.
module arbiter2_leaf_ctrl
    import noc_arb_pkg::*;
#(
    parameter int W        = FLIT_W,
    parameter int TAIL_BIT = W - 1
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         s_data,
    output logic         s_valid,
    input  logic         s_ready
);

    arb_state_t   state_q, state_d;
    logic         prio_q, prio_d;

    logic         can_take;
    logic         s_free;
    logic         head_ok;
    logic         any_req;
    logic         winner;
    logic         sel;
    logic         rdy0, rdy1;
    logic         xfer0, xfer1, xfer;
    logic         head_xfer;
    logic [W-1:0] mux_data;
    logic         flit_tail;

    assign head_ok = can_take & s_free;

    // Preferred input wins if it asks; otherwise the other one (don't-care when idle).
    always_comb begin
        any_req = in0_valid | in1_valid;
        if (prio_q) begin
            winner = in1_valid ? 1'b1 : 1'b0;
        end else begin
            winner = in0_valid ? 1'b0 : 1'b1;
        end
    end

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        sel  = 1'b0;
        case (state_q)
            IDLE: begin
                sel = winner;
                if (any_req) begin
                    rdy0 = ~winner & head_ok;
                    rdy1 =  winner & head_ok;
                end
            end
            LOCK0: begin
                sel  = 1'b0;
                rdy0 = can_take;
            end
            LOCK1: begin
                sel  = 1'b1;
                rdy1 = can_take;
            end
            default: ;
        endcase
    end

    // Readies drop the moment reset asserts, before the flops settle.
    assign in0_ready = rdy0 & _RESET;
    assign in1_ready = rdy1 & _RESET;

    assign xfer0     = in0_valid & in0_ready;
    assign xfer1     = in1_valid & in1_ready;
    assign xfer      = xfer0 | xfer1;
    assign head_xfer = xfer & (state_q == IDLE);
    assign mux_data  = sel ? in1_data : in0_data;
    assign flit_tail = mux_data[TAIL_BIT];

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (head_xfer) begin
                    prio_d = ~winner;
                    if (!flit_tail) begin
                        state_d = winner ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (xfer && flit_tail) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    flit_reg_stage #(.W(W)) u_out_stage (
        .clk_i       (CLK),
        .rst_ni      (_RESET),
        .in_valid_i  (xfer),
        .in_data_i   (mux_data),
        .in_ready_o  (can_take),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
    );

    // Token slot reloads on a new head even while draining, so S has no bubble.
    flit_reg_stage #(.W(1)) u_s_stage (
        .clk_i       (CLK),
        .rst_ni      (_RESET),
        .in_valid_i  (head_xfer),
        .in_data_i   (winner),
        .in_ready_o  (s_free),
        .out_valid_o (s_valid),
        .out_data_o  (s_data),
        .out_ready_i (s_ready)
    );

endmodule

// File: tb/tb_arbiter2_leaf_ctrl.sv
// Bench for arbiter2_leaf_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a packet-level reference model.
module tb_arbiter2_leaf_ctrl;
    import noc_arb_pkg::*;

    localparam int W = FLIT_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in0_data = '0, in1_data = '0;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic         in0_ready, in1_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         s_data, s_valid;
    logic         s_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arbiter2_leaf_ctrl #(.W(W), .TAIL_BIT(W-1)) dut (
        .CLK       (clk),
        ._RESET    (rst_n),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready)
    );

    // Upstream protocol: a valid flit not yet accepted must stay, unchanged.
    logic         p_v0, p_r0, p_v1, p_r1;
    logic [W-1:0] p_d0, p_d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_v0 <= 1'b0; p_r0 <= 1'b0; p_d0 <= '0;
            p_v1 <= 1'b0; p_r1 <= 1'b0; p_d1 <= '0;
        end else begin
            assert (!(p_v0 && !p_r0) || (in0_valid && in0_data == p_d0))
                else $error("protocol: in0 flit withdrawn or changed before acceptance");
            assert (!(p_v1 && !p_r1) || (in1_valid && in1_data == p_d1))
                else $error("protocol: in1 flit withdrawn or changed before acceptance");
            p_v0 <= in0_valid; p_r0 <= in0_ready; p_d0 <= in0_data;
            p_v1 <= in1_valid; p_r1 <= in1_ready; p_d1 <= in1_data;
        end
    end

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         orr;
        logic         sr;
        logic         er0;
        logic         er1;
        logic         eov;
        logic [W-1:0] eod;
        logic         esv;
        logic         esd;
    } vec_t;

    function automatic vec_t mk(input int rst, input int v0, input int d0, input int v1,
                                input int d1, input int orr, input int sr, input int er0,
                                input int er1, input int eov, input int eod, input int esv,
                                input int esd);
        vec_t v;
        v.rst = 1'(rst); v.v0 = 1'(v0); v.d0 = W'(d0); v.v1 = 1'(v1); v.d1 = W'(d1);
        v.orr = 1'(orr); v.sr = 1'(sr); v.er0 = 1'(er0); v.er1 = 1'(er1);
        v.eov = 1'(eov); v.eod = W'(eod); v.esv = 1'(esv); v.esd = 1'(esd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int v0, input int d0, input int v1, input int d1,
                         input int orr, input int sr);
        in0_valid = 1'(v0); in0_data = W'(d0);
        in1_valid = 1'(v1); in1_data = W'(d1);
        out_ready = 1'(orr); s_ready  = 1'(sr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input int e0, input int e1);
        #1;
        chk({tag, ".in0_ready"}, 32'(in0_ready), e0);
        chk({tag, ".in1_ready"}, 32'(in1_ready), e1);
    endtask

    task automatic chk_regs(input string tag, input int eov, input int eod,
                            input int esv, input int esd);
        chk({tag, ".out_valid"}, 32'(out_valid), eov);
        if (eov != 0) chk({tag, ".out_data"}, 32'(out_data), eod);
        chk({tag, ".s_valid"}, 32'(s_valid), esv);
        if (esv != 0) chk({tag, ".s_data"}, 32'(s_data), esd);
    endtask

    // Reset with both requesters pushing: readies must still read 0.
    task automatic do_reset(input string tag);
        drive(1, 'h0AB, 1, 'h0CD, 1, 1);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_in0_ready"}, 32'(in0_ready), 0);
        chk({tag, ".rst_in1_ready"}, 32'(in1_ready), 0);
        chk({tag, ".rst_out_valid"}, 32'(out_valid), 0);
        chk({tag, ".rst_s_valid"},   32'(s_valid),   0);
        tick();
        chk({tag, ".rst_out_data"}, 32'(out_data), 0);
        chk({tag, ".rst_s_data"},   32'(s_data),   0);
        drive(0, 0, 0, 0, 1, 1);
        rst_n = 1'b1;
    endtask

    // Random-phase state: generators, reference model and scoreboard.
    logic         g_v[2];
    logic [W-1:0] g_flit[2];
    int           g_rem[2];
    int           g_seq[2];
    logic [W-1:0] sent0[$], sent1[$];
    int           pkt_src_q[$], s_tok_q[$];
    int           cur_src;
    logic         m_ov, m_sv, m_sd;
    logic [W-1:0] m_od;
    int           m_lock, m_prio;

    initial begin
        vec_t tbl[$];

        // T1: single-flit packet; T2: contention from reset; T3: locked packet;
        // T5: S stalled while a packet body keeps flowing.
        //              rst v0 d0    v1 d1    or sr  r0 r1 ov od    sv sd
        tbl.push_back(mk(0, 1, 'h155, 0, 'h000, 1, 1, 1, 0, 1, 'h155, 1, 0));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h000, 1, 1, 0, 0, 0, 'h000, 0, 0));
        tbl.push_back(mk(1, 1, 'h101, 1, 'h102, 1, 1, 1, 0, 1, 'h101, 1, 0));
        tbl.push_back(mk(0, 1, 'h103, 1, 'h102, 1, 1, 0, 1, 1, 'h102, 1, 1));
        tbl.push_back(mk(0, 1, 'h103, 0, 'h000, 1, 1, 1, 0, 1, 'h103, 1, 0));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h000, 1, 1, 0, 0, 0, 'h000, 0, 0));
        tbl.push_back(mk(1, 1, 'h011, 0, 'h000, 1, 1, 1, 0, 1, 'h011, 1, 0));
        tbl.push_back(mk(0, 1, 'h012, 1, 'h1AA, 1, 1, 1, 0, 1, 'h012, 0, 0));
        tbl.push_back(mk(0, 1, 'h113, 1, 'h1AA, 1, 1, 1, 0, 1, 'h113, 0, 0));
        tbl.push_back(mk(0, 0, 'h000, 1, 'h1AA, 1, 1, 0, 1, 1, 'h1AA, 1, 1));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h000, 1, 1, 0, 0, 0, 'h000, 0, 0));
        tbl.push_back(mk(1, 1, 'h021, 0, 'h000, 1, 0, 1, 0, 1, 'h021, 1, 0));
        tbl.push_back(mk(0, 1, 'h022, 1, 'h1BB, 1, 0, 1, 0, 1, 'h022, 1, 0));
        tbl.push_back(mk(0, 1, 'h123, 1, 'h1BB, 1, 0, 1, 0, 1, 'h123, 1, 0));
        tbl.push_back(mk(0, 0, 'h000, 1, 'h1BB, 1, 0, 0, 0, 0, 'h000, 1, 0));
        tbl.push_back(mk(0, 0, 'h000, 1, 'h1BB, 1, 0, 0, 0, 0, 'h000, 1, 0));
        tbl.push_back(mk(0, 0, 'h000, 1, 'h1BB, 1, 1, 0, 1, 1, 'h1BB, 1, 1));
        tbl.push_back(mk(0, 0, 'h000, 0, 'h000, 1, 1, 0, 0, 0, 'h000, 0, 0));

        tick();
        do_reset("init");
        for (int k = 0; k < tbl.size(); k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            if (tbl[k].rst) do_reset(tag);
            drive(int'(tbl[k].v0), int'(tbl[k].d0), int'(tbl[k].v1), int'(tbl[k].d1),
                  int'(tbl[k].orr), int'(tbl[k].sr));
            chk_rdy(tag, int'(tbl[k].er0), int'(tbl[k].er1));
            tick();
            chk_regs(tag, int'(tbl[k].eov), int'(tbl[k].eod), int'(tbl[k].esv), int'(tbl[k].esd));
        end

        // T4: output backpressure for 4 cycles mid-packet, in1 waiting.
        do_reset("t4");
        drive(1, 'h041, 0, 0, 1, 1);
        chk_rdy("t4.head", 1, 0);
        tick();
        chk_regs("t4.head", 1, 'h041, 1, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 'h042, 1, 'h1CC, 0, 1);
            chk_rdy($sformatf("t4.stall%0d", k), 0, 0);
            tick();
            chk_regs($sformatf("t4.stall%0d", k), 1, 'h041, 0, 0);
        end
        drive(1, 'h042, 1, 'h1CC, 1, 1);
        chk_rdy("t4.resume", 1, 0);
        tick();
        chk_regs("t4.resume", 1, 'h042, 0, 0);
        drive(1, 'h143, 1, 'h1CC, 1, 1);
        chk_rdy("t4.tail", 1, 0);
        tick();
        chk_regs("t4.tail", 1, 'h143, 0, 0);
        drive(0, 0, 1, 'h1CC, 1, 1);
        chk_rdy("t4.next", 0, 1);
        tick();
        chk_regs("t4.next", 1, 'h1CC, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        chk_rdy("t4.idle", 0, 0);
        tick();
        chk_regs("t4.idle", 0, 0, 0, 0);

        // T6: reset pulse while in1 owns the output between flits.
        do_reset("t6");
        drive(0, 0, 1, 'h051, 1, 1);
        chk_rdy("t6.head", 0, 1);
        tick();
        chk_regs("t6.head", 1, 'h051, 1, 1);
        drive(0, 0, 1, 'h052, 1, 1);
        chk_rdy("t6.body", 0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6.pulse.out_valid", 32'(out_valid), 0);
        chk("t6.pulse.s_valid",   32'(s_valid),   0);
        chk("t6.pulse.in1_ready", 32'(in1_ready), 0);
        drive(1, 'h161, 1, 'h171, 1, 1);
        chk_rdy("t6.inreset", 0, 0);
        rst_n = 1'b1;
        chk_rdy("t6.release", 1, 0);
        tick();
        chk_regs("t6.first", 1, 'h161, 1, 0);
        drive(0, 0, 1, 'h171, 1, 1);
        chk_rdy("t6.second", 0, 1);
        tick();
        chk_regs("t6.second", 1, 'h171, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        chk_rdy("t6.idle", 0, 0);
        tick();
        chk_regs("t6.idle", 0, 0, 0, 0);

        // Randomized traffic: packets of 1-4 flits tagged {tail, src, seq}.
        do_reset("rnd");
        for (int i = 0; i < 2; i++) begin
            g_v[i] = 1'b0; g_flit[i] = '0; g_rem[i] = 0; g_seq[i] = 0;
        end
        cur_src = -1;
        m_ov = 1'b0; m_od = '0; m_sv = 1'b0; m_sd = 1'b0; m_lock = -1; m_prio = 0;

        for (int cyc = 0; cyc < 2060; cyc++) begin
            logic         draining, orr, sr, e0, e1, can_take, head_ok;
            logic         sv_v[2];
            logic [W-1:0] sv_f[2];
            logic         a0, a1, ov_pre, sv_pre, sd_pre;
            logic [W-1:0] od_pre;
            int           grant, acc, src;

            draining = (cyc >= 2000);
            for (int i = 0; i < 2; i++) begin
                if (!g_v[i] && (g_rem[i] > 0 || (!draining && $urandom_range(0, 99) < 60))) begin
                    if (g_rem[i] == 0) g_rem[i] = $urandom_range(1, 4);
                    g_flit[i]      = '0;
                    g_flit[i][W-1] = (g_rem[i] == 1);
                    g_flit[i][7]   = i[0];
                    g_flit[i][6:0] = g_seq[i][6:0];
                    g_v[i]         = 1'b1;
                end
            end
            orr = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
            sr  = draining ? 1'b1 : ($urandom_range(0, 2) != 0);
            drive(int'(g_v[0]), int'(g_flit[0]), int'(g_v[1]), int'(g_flit[1]), int'(orr), int'(sr));
            sv_v[0] = g_v[0]; sv_f[0] = g_flit[0];
            sv_v[1] = g_v[1]; sv_f[1] = g_flit[1];

            // Expected readies from the arbitration rules.
            can_take = !m_ov || orr;
            head_ok  = can_take && (!m_sv || sr);
            e0 = 1'b0; e1 = 1'b0;
            if (m_lock == 0) e0 = can_take;
            else if (m_lock == 1) e1 = can_take;
            else begin
                if (sv_v[m_prio]) grant = m_prio;
                else if (sv_v[1 - m_prio]) grant = 1 - m_prio;
                else grant = -1;
                if (grant == 0) e0 = head_ok;
                if (grant == 1) e1 = head_ok;
            end
            chk_rdy("rnd", int'(e0), int'(e1));

            a0 = in0_valid & in0_ready;
            a1 = in1_valid & in1_ready;
            ov_pre = out_valid; od_pre = out_data;
            sv_pre = s_valid;   sd_pre = s_data;
            tick();

            // Scoreboard: every output flit is the oldest unsent flit of its source,
            // packets never interleave, and S tokens name the packet sources in order.
            if (ov_pre && orr) begin
                src = int'(od_pre[7]);
                if ((src == 0 && sent0.size() == 0) || (src == 1 && sent1.size() == 0)) begin
                    n_tests++; n_fail++;
                    $display("FAIL rnd.out_flit: got %0h, expected nothing pending from in%0d", od_pre, src);
                end else begin
                    chk("rnd.out_flit", 32'(od_pre), 32'(src == 0 ? sent0.pop_front() : sent1.pop_front()));
                end
                if (cur_src < 0) pkt_src_q.push_back(src);
                else chk("rnd.no_interleave", src, cur_src);
                cur_src = is_tail(od_pre) ? -1 : src;
            end
            if (sv_pre && sr) s_tok_q.push_back(int'(sd_pre));
            while (s_tok_q.size() > 0 && pkt_src_q.size() > 0)
                chk("rnd.s_token", s_tok_q.pop_front(), pkt_src_q.pop_front());

            if (a0) begin sent0.push_back(sv_f[0]); g_v[0] = 1'b0; g_rem[0]--; g_seq[0]++; end
            if (a1) begin sent1.push_back(sv_f[1]); g_v[1] = 1'b0; g_rem[1]--; g_seq[1]++; end

            // Reference model advance.
            if (e0 && sv_v[0]) acc = 0;
            else if (e1 && sv_v[1]) acc = 1;
            else acc = -1;
            if (acc >= 0) begin
                m_ov = 1'b1; m_od = sv_f[acc];
            end else if (orr) m_ov = 1'b0;
            if (acc >= 0 && m_lock < 0) begin
                m_sv = 1'b1; m_sd = acc[0]; m_prio = 1 - acc;
            end else if (sr) m_sv = 1'b0;
            if (acc >= 0) begin
                if (m_lock < 0) begin
                    if (!is_tail(sv_f[acc])) m_lock = acc;
                end else if (is_tail(sv_f[acc])) m_lock = -1;
            end
            chk_regs("rnd", int'(m_ov), int'(m_od), int'(m_sv), int'(m_sd));
        end

        chk("rnd.drain.sent0_left", sent0.size(), 0);
        chk("rnd.drain.sent1_left", sent1.size(), 0);
        chk("rnd.drain.pkt_left",   pkt_src_q.size(), 0);
        chk("rnd.drain.tok_left",   s_tok_q.size(), 0);
        chk("rnd.drain.in0_pending", 32'(g_v[0]), 0);
        chk("rnd.drain.in1_pending", 32'(g_v[1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
